// File: rtl/utlb_refill_pkg.sv
// utlb_refill_pkg
// Shared definitions for the micro-TLB refill block:
//   - utlb_state_e : refill FSM states (IDLE -> REQ -> RESP)
//   - CAUSE_*      : bit positions of the one-hot fault cause vector
//   - utlb_entry_t : layout of one cached 4 KB translation
//   - encodeCause  : collapses the joint TLB fault flags into a one-hot cause
package utlb_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } utlb_state_e;

  localparam int CAUSE_MOD   = 0;
  localparam int CAUSE_INVAL = 1;
  localparam int CAUSE_MISS  = 2;
  localparam int CAUSE_ADE   = 3;

  // region is va[63:62], vpn is va[39:12]; wok marks the page as store-safe
  typedef struct packed {
    logic        valid;
    logic [1:0]  region;
    logic [27:0] vpn;
    logic [7:0]  asid;
    logic [19:0] pfn;
    logic        cache;
    logic        wok;
  } utlb_entry_t;

  // Several joint TLB fault lines can be high at once; only the most
  // important one is reported: ade > miss > inval > mod.
  function automatic logic [3:0] encodeCause(input logic ade, input logic miss,
                                             input logic inval, input logic mod);
    logic [3:0] cause;
    cause = '0;
    if (ade)        cause[CAUSE_ADE]   = 1'b1;
    else if (miss)  cause[CAUSE_MISS]  = 1'b1;
    else if (inval) cause[CAUSE_INVAL] = 1'b1;
    else if (mod)   cause[CAUSE_MOD]   = 1'b1;
    return cause;
  endfunction

endpackage

// File: rtl/utlb_refill_cam.sv
// utlb_refill_cam
// Entry array of the micro-TLB. Lookup is purely combinational; the only
// state is the entry array itself, written through a registered port.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_region/i_vpn/i_asid  lookup key, i_wr = lookup is a store
//   o_hit, o_hitIdx        full hit (tag match and store permission)
//   o_pfn, o_cache         translation of the hitting entry
//   o_tagHit, o_tagIdx     tag match ignoring store permission
//   o_validVec             per-entry valid bits (for victim selection)
//   i_clr                  clear all valid bits (wins over a write)
//   i_we, i_wIdx, i_wEntry entry write port
module utlb_refill_cam
  import utlb_refill_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDXW    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_region,
  input  logic [27:0]        i_vpn,
  input  logic [7:0]         i_asid,
  input  logic               i_wr,
  output logic               o_hit,
  output logic [IDXW-1:0]    o_hitIdx,
  output logic [19:0]        o_pfn,
  output logic               o_cache,
  output logic               o_tagHit,
  output logic [IDXW-1:0]    o_tagIdx,
  output logic [ENTRIES-1:0] o_validVec,
  input  logic               i_clr,
  input  logic               i_we,
  input  logic [IDXW-1:0]    i_wIdx,
  input  utlb_entry_t        i_wEntry
);

  utlb_entry_t r_entries [ENTRIES];
  logic [ENTRIES-1:0] w_tagVec;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) r_entries[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < ENTRIES; i++) r_entries[i].valid <= 1'b0;
    end else if (i_we) begin
      r_entries[i_wIdx] <= i_wEntry;
    end
  end

  always_comb begin
    w_tagVec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_tagVec[i] = r_entries[i].valid &&
                    (r_entries[i].region == i_region) &&
                    (r_entries[i].vpn == i_vpn) &&
                    (r_entries[i].asid == i_asid);
    end
  end

  // Refills overwrite a tag-matching entry in place, so at most one entry
  // can match and the encode below never has to arbitrate.
  always_comb begin
    o_hit      = 1'b0;
    o_hitIdx   = '0;
    o_pfn      = '0;
    o_cache    = 1'b0;
    o_tagHit   = 1'b0;
    o_tagIdx   = '0;
    o_validVec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_validVec[i] = r_entries[i].valid;
      if (w_tagVec[i]) begin
        o_tagHit = 1'b1;
        o_tagIdx = IDXW'(i);
        if (!i_wr || r_entries[i].wok) begin
          o_hit    = 1'b1;
          o_hitIdx = IDXW'(i);
          o_pfn    = r_entries[i].pfn;
          o_cache  = r_entries[i].cache;
        end
      end
    end
  end

endmodule

// File: rtl/utlb_refill.sv
// utlb_refill
// Micro-TLB between a pipeline stage and the joint TLB. Hits are answered
// combinationally; a miss stalls the pipeline, sends one request to the
// joint TLB, captures the answer, fills an entry (or reports the fault)
// and delivers the result in the RESP cycle.
// Ports:
//   clk, rst, phi2         clock, async active-high reset, phase strobe
//   lreq/lva/lwr           pipeline lookup
//   lpa/lcache/lstall      lookup result and stall
//   lerr + lmiss/linval/lmod/lade   fault result and one-hot cause
//   jtlbreq/jtlbva/jtlbwr  request to the joint TLB
//   jtlbpa..jtlbade        joint TLB response
//   asid/mode/mode64       context; any change flushes the array
//   flush                  explicit flush from CP0
//   missctr                refill counter, only when UTLB_PERF_EN is defined
module utlb_refill
  import utlb_refill_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDXW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic        lreq,
  input  logic [63:0] lva,
  input  logic        lwr,
  output logic [31:0] lpa,
  output logic        lcache,
  output logic        lstall,
  output logic        lerr,
  output logic        lmiss,
  output logic        linval,
  output logic        lmod,
  output logic        lade,
  output logic        jtlbreq,
  output logic [63:0] jtlbva,
  output logic        jtlbwr,
  input  logic [31:0] jtlbpa,
  input  logic        jtlbcache,
  input  logic        jtlbmiss,
  input  logic        jtlbinval,
  input  logic        jtlbmod,
  input  logic        jtlbade,
  input  logic [7:0]  asid,
  input  logic [1:0]  mode,
  input  logic        mode64,
  input  logic        flush
`ifdef UTLB_PERF_EN
  , output logic [31:0] missctr
`endif
);

  utlb_state_e r_state, w_nextState;

  logic [63:0]        r_va;
  logic               r_wr, r_tagHit, r_cache, r_mode64;
  logic [IDXW-1:0]    r_tagIdx, r_ptr;
  logic [19:0]        r_pfn;
  logic [3:0]         r_cause;
  logic [7:0]         r_asid;
  logic [1:0]         r_mode;

  logic               w_hit, w_tagHit, w_camCache;
  logic [IDXW-1:0]    w_hitIdx, w_tagIdx, w_victim, w_wIdx;
  logic [19:0]        w_camPfn;
  logic [ENTRIES-1:0] w_validVec;
  logic [3:0]         w_cause;
  logic               w_ctxChg, w_clr, w_startMiss, w_we;
  utlb_entry_t        w_wEntry;
  logic               w_unused;

  assign w_unused = ^{lva[61:40], jtlbpa[11:0], w_hitIdx};

  assign w_cause     = encodeCause(jtlbade, jtlbmiss, jtlbinval, jtlbmod);
  assign w_ctxChg    = (asid != r_asid) || (mode != r_mode) || (mode64 != r_mode64);
  assign w_clr       = phi2 && (flush || w_ctxChg);
  assign w_startMiss = phi2 && (r_state == ST_IDLE) && lreq && !w_hit;
  // A clear on the same edge as the response wins, so nothing stale survives
  assign w_we        = phi2 && (r_state == ST_REQ) && !(|w_cause) && !w_clr;
  // Store upgrade of an existing page rewrites that slot to avoid duplicates
  assign w_wIdx      = r_tagHit ? r_tagIdx : w_victim;

  assign jtlbva = r_va;
  assign jtlbwr = r_wr;

  utlb_refill_cam #(.ENTRIES(ENTRIES), .IDXW(IDXW)) u_cam (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_region   (lva[63:62]),
    .i_vpn      (lva[39:12]),
    .i_asid     (asid),
    .i_wr       (lwr),
    .o_hit      (w_hit),
    .o_hitIdx   (w_hitIdx),
    .o_pfn      (w_camPfn),
    .o_cache    (w_camCache),
    .o_tagHit   (w_tagHit),
    .o_tagIdx   (w_tagIdx),
    .o_validVec (w_validVec),
    .i_clr      (w_clr),
    .i_we       (w_we),
    .i_wIdx     (w_wIdx),
    .i_wEntry   (w_wEntry)
  );

  // Victim: lowest-index invalid entry, else the round-robin pointer
  always_comb begin
    w_victim = r_ptr;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!w_validVec[i]) w_victim = IDXW'(i);
    end
  end

  always_comb begin
    w_wEntry        = '0;
    w_wEntry.valid  = 1'b1;
    w_wEntry.region = r_va[63:62];
    w_wEntry.vpn    = r_va[39:12];
    w_wEntry.asid   = asid;
    w_wEntry.pfn    = jtlbpa[31:12];
    w_wEntry.cache  = jtlbcache;
    w_wEntry.wok    = r_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else if (phi2) r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    lpa         = {w_camPfn, lva[11:0]};
    lcache      = w_camCache;
    lstall      = 1'b0;
    lerr        = 1'b0;
    lmiss       = 1'b0;
    linval      = 1'b0;
    lmod        = 1'b0;
    lade        = 1'b0;
    jtlbreq     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (lreq && !w_hit) begin
          lstall      = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        jtlbreq     = 1'b1;
        lstall      = 1'b1;
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        // Served from the response register, so a flush after the fill
        // cannot take the result away
        lpa         = {r_pfn, r_va[11:0]};
        lcache      = r_cache;
        lerr        = |r_cause;
        lmiss       = r_cause[CAUSE_MISS];
        linval      = r_cause[CAUSE_INVAL];
        lmod        = r_cause[CAUSE_MOD];
        lade        = r_cause[CAUSE_ADE];
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Context is sampled every phi2 edge so a change is seen exactly once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asid   <= '0;
      r_mode   <= '0;
      r_mode64 <= 1'b0;
      r_ptr    <= '0;
    end else if (phi2) begin
      r_asid   <= asid;
      r_mode   <= mode;
      r_mode64 <= mode64;
      if (w_clr) r_ptr <= '0;
      else if (w_we) r_ptr <= (r_ptr == IDXW'(ENTRIES - 1)) ? '0 : r_ptr + IDXW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_va     <= '0;
      r_wr     <= 1'b0;
      r_tagHit <= 1'b0;
      r_tagIdx <= '0;
      r_pfn    <= '0;
      r_cache  <= 1'b0;
      r_cause  <= '0;
    end else begin
      if (w_startMiss) begin
        r_va     <= lva;
        r_wr     <= lwr;
        r_tagHit <= w_tagHit;
        r_tagIdx <= w_tagIdx;
      end
      if (phi2 && (r_state == ST_REQ)) begin
        r_pfn   <= jtlbpa[31:12];
        r_cache <= jtlbcache;
        r_cause <= w_cause;
      end
    end
  end

`ifdef UTLB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) missctr <= '0;
    else if (w_startMiss) missctr <= missctr + 32'd1;
  end
`endif

endmodule

// File: tb/tb_utlb_refill.sv
// tb_utlb_refill
// Directed bench for utlb_refill (ENTRIES=4). Each scenario task drives a
// sequence of lookups and joint TLB answers and compares outputs against
// hand-computed values. Inputs change on the falling edge and outputs are
// sampled 1 ns later, away from the active rising edge.
module tb_utlb_refill;

  logic        clk = 1'b0;
  logic        rst, phi2, lreq, lwr, flush, mode64;
  logic [63:0] lva;
  logic [31:0] lpa, jtlbpa;
  logic        lcache, lstall, lerr, lmiss, linval, lmod, lade;
  logic        jtlbreq, jtlbwr, jtlbcache, jtlbmiss, jtlbinval, jtlbmod, jtlbade;
  logic [63:0] jtlbva;
  logic [7:0]  asid;
  logic [1:0]  mode;
`ifdef UTLB_PERF_EN
  logic [31:0] missctr;
`endif

  int nVec  = 0;
  int nFail = 0;

  localparam logic [63:0] VA_A  = 64'h0000_0000_0040_1234;
  localparam logic [63:0] VA_P0 = 64'h0000_0000_1000_00ab;
  localparam logic [63:0] VA_Q  = 64'h0000_0000_2000_0567;
  localparam logic [63:0] VA_R  = 64'h0000_0000_3000_0010;
  localparam logic [63:0] VA_S  = 64'h0000_0000_4000_0020;

  always #5 clk = ~clk;

  utlb_refill #(.ENTRIES(4), .IDXW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .phi2      (phi2),
    .lreq      (lreq),
    .lva       (lva),
    .lwr       (lwr),
    .lpa       (lpa),
    .lcache    (lcache),
    .lstall    (lstall),
    .lerr      (lerr),
    .lmiss     (lmiss),
    .linval    (linval),
    .lmod      (lmod),
    .lade      (lade),
    .jtlbreq   (jtlbreq),
    .jtlbva    (jtlbva),
    .jtlbwr    (jtlbwr),
    .jtlbpa    (jtlbpa),
    .jtlbcache (jtlbcache),
    .jtlbmiss  (jtlbmiss),
    .jtlbinval (jtlbinval),
    .jtlbmod   (jtlbmod),
    .jtlbade   (jtlbade),
    .asid      (asid),
    .mode      (mode),
    .mode64    (mode64),
    .flush     (flush)
`ifdef UTLB_PERF_EN
    , .missctr (missctr)
`endif
  );

  // Present a lookup in the next cycle and let combinational outputs settle
  task automatic lookup(input logic [63:0] va, input logic wr);
    @(negedge clk);
    lreq = 1'b1; lva = va; lwr = wr;
    #1;
  endtask

  // Called in the IDLE miss cycle: answers during REQ, returns in RESP
  task automatic finishRefill(input logic [31:0] pa, input logic c, input logic [3:0] f);
    @(negedge clk);
    jtlbpa = pa; jtlbcache = c;
    {jtlbade, jtlbmiss, jtlbinval, jtlbmod} = f;
    @(negedge clk);
    jtlbpa = '0; jtlbcache = 1'b0;
    {jtlbade, jtlbmiss, jtlbinval, jtlbmod} = 4'b0;
    #1;
  endtask

  task automatic pulseFlush();
    @(negedge clk);
    lreq = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; phi2 = 1'b1; lreq = 1'b0; lva = '0; lwr = 1'b0; flush = 1'b0;
    asid = 8'h05; mode = 2'd0; mode64 = 1'b1;
    jtlbpa = '0; jtlbcache = 1'b0; jtlbmiss = 1'b0; jtlbinval = 1'b0; jtlbmod = 1'b0; jtlbade = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL reset_lstall: got %b want 0", lstall); end
    nVec++; if (lerr !== 1'b0) begin nFail++; $display("[TB] FAIL reset_lerr: got %b want 0", lerr); end
    nVec++; if (jtlbreq !== 1'b0) begin nFail++; $display("[TB] FAIL reset_jtlbreq: got %b want 0", jtlbreq); end
    nVec++; if ({lade, lmiss, linval, lmod} !== 4'b0) begin nFail++; $display("[TB] FAIL reset_cause: got %b want 0000", {lade, lmiss, linval, lmod}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    lookup(VA_A, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL load_idle_stall: got %b want 1", lstall); end
    nVec++; if (jtlbreq !== 1'b0) begin nFail++; $display("[TB] FAIL load_idle_req: got %b want 0", jtlbreq); end
    @(negedge clk);
    #1;
    nVec++; if (jtlbreq !== 1'b1) begin nFail++; $display("[TB] FAIL load_req: got %b want 1", jtlbreq); end
    nVec++; if (jtlbva !== VA_A) begin nFail++; $display("[TB] FAIL load_jtlbva: got %h want %h", jtlbva, VA_A); end
    nVec++; if (jtlbwr !== 1'b0) begin nFail++; $display("[TB] FAIL load_jtlbwr: got %b want 0", jtlbwr); end
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL load_req_stall: got %b want 1", lstall); end
    jtlbpa = 32'h0012_3000; jtlbcache = 1'b1;
    @(negedge clk);
    jtlbpa = '0; jtlbcache = 1'b0;
    #1;
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL load_resp_stall: got %b want 0", lstall); end
    nVec++; if (lerr !== 1'b0) begin nFail++; $display("[TB] FAIL load_resp_lerr: got %b want 0", lerr); end
    nVec++; if (lpa !== 32'h0012_3234) begin nFail++; $display("[TB] FAIL load_resp_lpa: got %h want 00123234", lpa); end
    nVec++; if (lcache !== 1'b1) begin nFail++; $display("[TB] FAIL load_resp_lcache: got %b want 1", lcache); end
    lookup(VA_A, 1'b0);
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL load_hit_stall: got %b want 0", lstall); end
    nVec++; if (lpa !== 32'h0012_3234) begin nFail++; $display("[TB] FAIL load_hit_lpa: got %h want 00123234", lpa); end
  endtask

  task automatic test_modify();
    lookup(VA_A, 1'b1);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL mod_store_miss: got %b want 1", lstall); end
    finishRefill(32'h0012_3000, 1'b1, 4'b0001);
    nVec++; if (lerr !== 1'b1) begin nFail++; $display("[TB] FAIL mod_lerr: got %b want 1", lerr); end
    nVec++; if ({lade, lmiss, linval, lmod} !== 4'b0001) begin nFail++; $display("[TB] FAIL mod_cause: got %b want 0001", {lade, lmiss, linval, lmod}); end
    lookup(VA_A, 1'b0);
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL mod_load_kept: got %b want 0", lstall); end
    nVec++; if (lpa !== 32'h0012_3234) begin nFail++; $display("[TB] FAIL mod_load_lpa: got %h want 00123234", lpa); end
    lookup(VA_A, 1'b1);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL mod_store_again: got %b want 1", lstall); end
    finishRefill(32'h0012_3000, 1'b1, 4'b0000);
    lookup(VA_A, 1'b1);
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL mod_store_hit: got %b want 0", lstall); end
  endtask

  task automatic test_victim();
    logic [63:0] va;
    logic [31:0] pa;
    pulseFlush();
    for (int k = 0; k < 5; k++) begin
      va = VA_P0 + 64'(k) * 64'h1000;
      pa = 32'h0050_0000 + 32'(k) * 32'h1000;
      lookup(va, 1'b0);
      nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL victim_fill%0d_miss: got %b want 1", k, lstall); end
      finishRefill(pa, 1'b0, 4'b0000);
    end
    for (int k = 1; k < 5; k++) begin
      va = VA_P0 + 64'(k) * 64'h1000;
      pa = 32'h0050_00ab + 32'(k) * 32'h1000;
      lookup(va, 1'b0);
      nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL victim_page%0d_hit: got %b want 0", k, lstall); end
      nVec++; if (lpa !== pa) begin nFail++; $display("[TB] FAIL victim_page%0d_lpa: got %h want %h", k, lpa, pa); end
    end
    lookup(VA_P0, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL victim_page0_evicted: got %b want 1", lstall); end
    finishRefill(32'h0050_0000, 1'b0, 4'b0000);
  endtask

  task automatic test_asid();
    @(negedge clk);
    lreq = 1'b0; asid = 8'h06;
    lookup(VA_P0 + 64'h2000, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL asid6_miss: got %b want 1", lstall); end
    finishRefill(32'h0050_2000, 1'b0, 4'b0000);
    @(negedge clk);
    lreq = 1'b0; asid = 8'h05;
    lookup(VA_P0 + 64'h3000, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL asid5_restore_miss: got %b want 1", lstall); end
    finishRefill(32'h0050_3000, 1'b0, 4'b0000);
    lookup(VA_P0 + 64'h3000, 1'b0);
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL asid5_refill_hit: got %b want 0", lstall); end
    nVec++; if (lpa !== 32'h0050_30ab) begin nFail++; $display("[TB] FAIL asid5_refill_lpa: got %h want 005030ab", lpa); end
  endtask

  task automatic test_flush_req();
    pulseFlush();
    lookup(VA_Q, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL flushreq_miss: got %b want 1", lstall); end
    @(negedge clk);
    jtlbpa = 32'h0077_7000; jtlbcache = 1'b0; flush = 1'b1;
    @(negedge clk);
    jtlbpa = '0; flush = 1'b0;
    #1;
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL flushreq_resp_stall: got %b want 0", lstall); end
    nVec++; if (lerr !== 1'b0) begin nFail++; $display("[TB] FAIL flushreq_resp_lerr: got %b want 0", lerr); end
    nVec++; if (lpa !== 32'h0077_7567) begin nFail++; $display("[TB] FAIL flushreq_resp_lpa: got %h want 00777567", lpa); end
    lookup(VA_Q, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL flushreq_no_fill: got %b want 1", lstall); end
    finishRefill(32'h0077_7000, 1'b0, 4'b0000);
  endtask

  task automatic test_fault_prio();
    lookup(VA_R, 1'b0);
    finishRefill(32'h0066_6000, 1'b1, 4'b1100);
    nVec++; if (lerr !== 1'b1) begin nFail++; $display("[TB] FAIL prio_ade_lerr: got %b want 1", lerr); end
    nVec++; if ({lade, lmiss, linval, lmod} !== 4'b1000) begin nFail++; $display("[TB] FAIL prio_ade_cause: got %b want 1000", {lade, lmiss, linval, lmod}); end
    lookup(VA_R, 1'b0);
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL prio_ade_no_fill: got %b want 1", lstall); end
    finishRefill(32'h0066_6000, 1'b1, 4'b0111);
    nVec++; if ({lade, lmiss, linval, lmod} !== 4'b0100) begin nFail++; $display("[TB] FAIL prio_miss_cause: got %b want 0100", {lade, lmiss, linval, lmod}); end
    lookup(VA_R, 1'b0);
    finishRefill(32'h0066_6000, 1'b1, 4'b0011);
    nVec++; if ({lade, lmiss, linval, lmod} !== 4'b0010) begin nFail++; $display("[TB] FAIL prio_inval_cause: got %b want 0010", {lade, lmiss, linval, lmod}); end
  endtask

  task automatic test_phi2_hold();
    @(negedge clk);
    phi2 = 1'b0; lreq = 1'b1; lva = VA_S; lwr = 1'b0;
    @(negedge clk);
    #1;
    nVec++; if (jtlbreq !== 1'b0) begin nFail++; $display("[TB] FAIL phi2_hold_req: got %b want 0", jtlbreq); end
    nVec++; if (lstall !== 1'b1) begin nFail++; $display("[TB] FAIL phi2_hold_stall: got %b want 1", lstall); end
    phi2 = 1'b1;
    finishRefill(32'h0044_4000, 1'b1, 4'b0000);
    nVec++; if (lpa !== 32'h0044_4020) begin nFail++; $display("[TB] FAIL phi2_resp_lpa: got %h want 00444020", lpa); end
  endtask

  task automatic test_rst_mid();
    lookup(VA_Q + 64'h1000, 1'b1);
    @(negedge clk);
    #1;
    nVec++; if (jtlbreq !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_req: got %b want 1", jtlbreq); end
    nVec++; if (jtlbwr !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_jtlbwr: got %b want 1", jtlbwr); end
    rst = 1'b1;
    #1;
    nVec++; if (jtlbreq !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_req_drop: got %b want 0", jtlbreq); end
    lreq = 1'b0;
    #1;
    nVec++; if (lstall !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_stall: got %b want 0", lstall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_modify();
    test_victim();
    test_asid();
    test_flush_req();
    test_fault_prio();
    test_phi2_hold();
    test_rst_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/utlb_refill.md
Name: utlb_refill

Overview:
- Micro-TLB sitting between a pipeline stage (instruction fetch or data access) and the shared joint TLB.
- Holds a small set of recently used 4 KB translations and answers pipeline lookups combinationally on a hit.
- On a miss it acts as the initiator toward the joint TLB: stalls the pipeline, issues one translation request, captures the response, fills an entry or reports the fault, then releases the stall.

Parameters:
ENTRIES, 4, number of cached translations (2 for the fetch instance); valid range 2-8.
IDXW, 2, log2(ENTRIES); must equal log2(ENTRIES).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
phi2  in  1  phase strobe; all state advances only on posedge clk with phi2=1
lreq  in  1  pipeline lookup request
lva  in  64  lookup virtual address
lwr  in  1  lookup is a store
lpa  out  32  physical address, valid when lreq && !lstall && !lerr
lcache  out  1  access is cacheable
lstall  out  1  pipeline must hold
lerr  out  1  fault result this cycle; the cause is in lmiss/linval/lmod/lade
lmiss  out  1  TLB refill or multi-hit fault
linval  out  1  invalid-page fault
lmod  out  1  modify fault
lade  out  1  address error
jtlbreq  out  1  request to joint TLB
jtlbva  out  64  request address
jtlbwr  out  1  request is a store
jtlbpa  in  32  joint TLB result address
jtlbcache  in  1  joint TLB cacheable
jtlbmiss  in  1  joint TLB miss
jtlbinval  in  1  joint TLB invalid
jtlbmod  in  1  joint TLB modify
jtlbade  in  1  joint TLB address error
asid  in  8  current EntryHi ASID
mode  in  2  current privilege mode
mode64  in  1  64-bit addressing active
flush  in  1  tlbwi/tlbwr/TS-set pulse from CP0

Behaviour:
- Entry fields: valid, region va[63:62], vpn va[39:12], asid, pfn[19:0], cache, wok.
  - wok means the entry is known store-safe.
- Hit rule, combinational: valid, region match, vpn match, asid match, and (!lwr || wok).
  - At most one entry can hit, by construction: a fill occurs only after a miss.
- Hit output: lpa = {pfn, lva[11:0]}, lcache = cache.
- Reset and flush: all valid bits clear, state IDLE, replacement pointer 0. Outputs at reset: lstall=0, lerr=0, jtlbreq=0, all fault bits 0.
- Implicit flush: a change of asid, mode or mode64 between phi2 edges clears all entries on that edge.
- FSM states IDLE, REQ, RESP.
  - IDLE: lreq && no hit → lstall=1 combinationally. On phi2, latch lva/lwr and go to REQ.
  - REQ: jtlbreq=1, jtlbva/jtlbwr come from the latches; lstall=1. On phi2, sample the joint TLB outputs into a response register and go to RESP.
    - No fault: fill the victim with wok=latched wr; pointer advances mod ENTRIES.
    - Any fault: no fill.
  - RESP: lstall=0 for one phi2 cycle.
    - Fault case: lerr=1 with the registered cause bits.
    - No-fault case: lpa/lcache come from the response register. This is valid even if the entry was immediately flushed.
    - Returns to IDLE on phi2.
- Latency: miss to result is 2 phi2 cycles of stall, result on the 3rd.
- Store to an entry with wok=0 counts as a miss. The refill overwrites the matching entry in place, not the victim, so no duplicate entry can exist.
- Victim choice: lowest-index invalid entry, else the round-robin pointer.
- Fault priority when several joint TLB fault outputs are high: ade > miss > inval > mod. Exactly one cause bit is set.
- flush during REQ or RESP: the entries are cleared, and the FSM still completes the in-flight request and delivers its result. The fill on that edge is suppressed.
- rst mid-request: immediate return to IDLE with jtlbreq deasserted.
- lreq dropped while stalled: the FSM completes. The RESP result is discarded by the pipeline.

Optional Feature:
- Macro: UTLB_PERF_EN.
- With the macro defined: adds an output port missctr (32 bits), which counts entries into REQ and wraps at 2^32. It resets to 0 on rst; flush does not clear it.
- Without the macro: the port and the counter are absent.

Decomposition:
- Shared package cpu.vh: entry field offsets, FSM state encodings, fault cause bit positions.
- One natural sub-module, utlb_cam: holds the entry array and does match plus hit-index encode. It is purely combinational, with a registered write port.

Test Plan:
- Load lva=0x0000_0000_0040_1234, lwr=0, joint TLB returns pa 0x0012_3000 → 2 stall cycles, RESP lpa=0x0012_3234. A repeat lookup hits with lstall=0.
- Load hit on page A, then store to A with jtlbmod=1 → miss, REQ, RESP lerr=1 lmod=1. Entry A is kept with wok=0; the next load of A hits.
- Fill ENTRIES+1 distinct pages → the 5th fill replaces entry 0. Page 0 then misses, and pages 1-4 hit.
- Change asid from 0x05 to 0x06 → all previously hit pages miss. Restore 0x05 → they miss again and refill.
- flush asserted in REQ → RESP delivers lpa from the response register, the array stays empty, and the next lookup misses.
- jtlbade=1 and jtlbmiss=1 together → lerr=1, lade=1, lmiss=0, no fill.
